// File: rtl/fifo_pkg.sv
// Shared definitions for the fifostack queue and its drain-side consumer.
package fifo_pkg;

    localparam int FIFO_DATA_W = 32;
    localparam int FIFO_DEPTH  = 8;
    localparam int FIFO_USABLE = 7;

    typedef enum logic [1:0] {
        DRN_IDLE = 2'd0,
        DRN_POP  = 2'd1,
        DRN_CAPT = 2'd2,
        DRN_SEND = 2'd3
    } drain_state_t;

endpackage

// File: rtl/fifo_drain_cksum.sv
// XOR accumulator over delivered stream words; built only when FIFO_DRAIN_CHECKSUM_EN is defined.
module fifo_drain_cksum
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fire,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] checksum
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;

    function automatic logic [DATA_W-1:0] fold_word(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] w
    );
        return acc ^ w;
    endfunction

    // Next accumulator value: cleared in reset, folded on each handshake.
    always_comb begin
        acc_d = acc_q;
        if (!reset) begin
            acc_d = {DATA_W{1'b0}};
        end else if (fire) begin
            acc_d = fold_word(acc_q, word);
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clock) begin
        acc_q <= acc_d;
    end

    assign checksum = acc_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains the fifostack queue into a valid/ready stream, one word in flight at a time.
// Optional XOR checksum over delivered words is enabled by defining FIFO_DRAIN_CHECKSUM_EN.
module fifo_drain_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic              fifo_enqueue,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_dequeue,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  drain_count,
    output logic [DATA_W-1:0] checksum
);

    drain_state_t      state_q;
    drain_state_t      state_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;
    logic [CNT_W-1:0]  drain_count_q;
    logic [CNT_W-1:0]  drain_count_d;
    logic              handshake_s;

    assign handshake_s = out_valid_q & out_ready;

    // Next-state, capture and counter logic; the dequeue pulse is combinational in POP.
    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        drain_count_d = drain_count_q;
        fifo_dequeue  = 1'b0;
        if (!reset) begin
            state_d       = DRN_IDLE;
            out_valid_d   = 1'b0;
            out_data_d    = {DATA_W{1'b0}};
            drain_count_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                DRN_IDLE: begin
                    if (!fifo_empty) begin
                        state_d = DRN_POP;
                    end else begin
                        state_d = DRN_IDLE;
                    end
                end
                DRN_POP: begin
                    // The queue ignores a simultaneous enqueue and dequeue, so back off and retry.
                    if (fifo_empty) begin
                        state_d = DRN_IDLE;
                    end else if (fifo_enqueue) begin
                        state_d = DRN_POP;
                    end else begin
                        fifo_dequeue = 1'b1;
                        state_d      = DRN_CAPT;
                    end
                end
                DRN_CAPT: begin
                    out_data_d  = fifo_data;
                    out_valid_d = 1'b1;
                    state_d     = DRN_SEND;
                end
                DRN_SEND: begin
                    if (handshake_s) begin
                        drain_count_d = drain_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        out_valid_d   = 1'b0;
                        if (!fifo_empty) begin
                            state_d = DRN_POP;
                        end else begin
                            state_d = DRN_IDLE;
                        end
                    end else begin
                        state_d = DRN_SEND;
                    end
                end
                default: begin
                    state_d     = DRN_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, stream and counter registers.
    always_ff @(posedge clock) begin
        state_q       <= state_d;
        out_valid_q   <= out_valid_d;
        out_data_q    <= out_data_d;
        drain_count_q <= drain_count_d;
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign drain_count = drain_count_q;

`ifdef FIFO_DRAIN_CHECKSUM_EN
    fifo_drain_cksum #(
        .DATA_W (DATA_W)
    ) u_cksum (
        .clock    (clock),
        .reset    (reset),
        .fire     (handshake_s),
        .word     (out_data_q),
        .checksum (checksum)
    );
`else
    assign checksum = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl against a behavioural 7-word queue model and scoreboard.
module tb_fifo_drain_ctrl;
    import fifo_pkg::*;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clock        = 1'b0;
    logic          reset        = 1'b0;
    logic          fifo_empty   = 1'b1;
    logic          fifo_enqueue = 1'b0;
    logic [DW-1:0] fifo_data    = '0;
    logic          fifo_dequeue;
    logic          out_valid;
    logic          out_ready    = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] drain_count;
    logic [DW-1:0] checksum;
    logic [DW-1:0] enq_word     = '0;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    logic [DW-1:0] qm[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    always #5 clock = ~clock;

    fifo_drain_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_enqueue (fifo_enqueue),
        .fifo_data    (fifo_data),
        .fifo_dequeue (fifo_dequeue),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .drain_count  (drain_count),
        .checksum     (checksum)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Queue model: registered data_out, 7 usable slots, enq together with deq is ignored.
    logic [DW-1:0] popped;
    always @(posedge clock) begin
        if (fifo_dequeue) pulses++;
        if (fifo_dequeue && !fifo_enqueue) begin
            if (qm.size() > 0) begin
                popped = qm.pop_front();
                fifo_data <= popped;
                exp_q.push_back(popped);
            end
        end else if (fifo_enqueue && !fifo_dequeue && qm.size() < FIFO_USABLE) begin
            qm.push_back(enq_word);
        end
        fifo_empty <= (qm.size() == 0);
    end

    // Monitor: scoreboard, count/checksum model and stream protocol rules.
    logic [CW-1:0] exp_cnt = '0;
    logic [DW-1:0] exp_ck  = '0;
    logic          prev_deq = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0, prev_rst = 1'b0;
    logic          deq_d1 = 1'b0, deq_d2 = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] want;
    logic          hs;
    always @(negedge clock) begin
        hs = reset && out_valid && out_ready;
        chk("drain_count", drain_count, exp_cnt);
`ifdef FIFO_DRAIN_CHECKSUM_EN
        chk("checksum", checksum, exp_ck);
`else
        chk("checksum", checksum, 64'd0);
`endif
        if (!reset) chk("deq_in_reset", fifo_dequeue, 1'b0);
        chk("collision", fifo_dequeue & fifo_enqueue, 1'b0);
        chk("double_pulse", prev_deq & fifo_dequeue, 1'b0);
        chk("deq_while_valid", fifo_dequeue & out_valid, 1'b0);
        if (prev_rst && prev_valid && !prev_hs) begin
            chk("valid_hold", out_valid, 1'b1);
            chk("data_hold", out_data, prev_data);
        end
        if (deq_d1) chk("capt_valid_low", out_valid, 1'b0);
        if (deq_d2) chk("latency", out_valid, 1'b1);
        if (hs) begin
            chk("outstanding", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                chk("data", out_data, want);
            end
            exp_cnt = exp_cnt + 1'b1;
            exp_ck  = exp_ck ^ out_data;
            got_q.push_back(out_data);
        end
        deq_d2 = deq_d1;
        deq_d1 = fifo_dequeue;
        if (!reset) begin
            exp_q.delete();
            exp_cnt = '0;
            exp_ck  = '0;
            deq_d1  = 1'b0;
            deq_d2  = 1'b0;
        end
        prev_deq   = fifo_dequeue;
        prev_valid = out_valid;
        prev_hs    = hs;
        prev_rst   = reset;
        prev_data  = out_data;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_enqueue = 1'b1;
        enq_word     = w;
        tick();
        fifo_enqueue = 1'b0;
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (qm.size() == 0 && exp_q.size() == 0 && !out_valid && fifo_empty) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk("drain_timeout", done, 1'b1);
        repeat (3) tick();
    endtask

    int p0;
    int n;
    logic seen;

    initial begin
        repeat (2) tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_count", drain_count, 64'd0);
        reset = 1'b1;

        // 1: three words straight through
        out_ready = 1'b1;
        p0 = pulses;
        push(32'h11); push(32'h22); push(32'h33);
        wait_drain();
        chk("t1_count", drain_count, 64'd3);
        chk("t1_pulses", pulses - p0, 3);
        n = got_q.size();
        chk("t1_w0", got_q[n-3], 64'h11);
        chk("t1_w1", got_q[n-2], 64'h22);
        chk("t1_w2", got_q[n-1], 64'h33);

        // 2: back-pressure holds the word
        out_ready = 1'b0;
        p0 = pulses;
        push(32'hA5);
        repeat (12) tick();
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_data", out_data, 64'hA5);
        chk("t2_count_held", drain_count, 64'd3);
        chk("t2_pulses", pulses - p0, 1);
        out_ready = 1'b1;
        wait_drain();
        chk("t2_count", drain_count, 64'd4);

        // 3: enqueue collides with POP for two cycles
        push(32'h5A);
        tick();
        fifo_enqueue = 1'b1; enq_word = 32'h66; #2;
        chk("t3_hold0", fifo_dequeue, 1'b0);
        tick();
        enq_word = 32'h77; #2;
        chk("t3_hold1", fifo_dequeue, 1'b0);
        tick();
        fifo_enqueue = 1'b0; #2;
        chk("t3_pulse", fifo_dequeue, 1'b1);
        wait_drain();
        n = got_q.size();
        chk("t3_w0", got_q[n-3], 64'h5A);
        chk("t3_w1", got_q[n-2], 64'h66);
        chk("t3_w2", got_q[n-1], 64'h77);

        // 4: reset during CAPT drops the in-flight word
        push(32'hA1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (fifo_dequeue) begin seen = 1'b1; break; end
            tick();
        end
        chk("t4_pulse_seen", seen, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        chk("t4_valid", out_valid, 1'b0);
        chk("t4_count", drain_count, 64'd0);
        push(32'hB2);
        for (int i = 0; i < 3; i++) begin
            chk("t4_no_deq", fifo_dequeue, 1'b0);
            tick();
        end
        reset = 1'b1;
        wait_drain();
        chk("t4_count_after", drain_count, 64'd1);
        chk("t4_word", got_q[got_q.size()-1], 64'hB2);

        // 5: fill to capacity (8th enqueue refused), then drain
        reset = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h100 + i);
        p0 = pulses;
        reset = 1'b1;
        wait_drain();
        repeat (10) tick();
        chk("t5_count", drain_count, 64'd7);
        chk("t5_pulses", pulses - p0, 7);
        chk("t5_empty", fifo_empty, 1'b1);
        n = got_q.size();
        for (int i = 0; i < 7; i++) chk("t5_word", got_q[n-7+i], 64'h100 + i);

        // 6: checksum of 0F, F0, FF folds back to zero
        reset = 1'b0; tick(); reset = 1'b1;
        push(32'h0F); push(32'hF0); push(32'hFF);
        wait_drain();
        chk("t6_checksum", checksum, 64'd0);
        chk("t6_count", drain_count, 64'd3);

        // Random traffic with back-pressure and occasional reset
        for (int i = 0; i < 600; i++) begin
            fifo_enqueue = ($urandom_range(0, 99) < 40);
            enq_word     = $urandom;
            out_ready    = ($urandom_range(0, 99) < 65);
            reset        = ($urandom_range(0, 149) != 0);
            tick();
        end
        fifo_enqueue = 1'b0;
        reset        = 1'b1;
        out_ready    = 1'b1;
        wait_drain();
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
